// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin front end that shares one combinational ALU
// between requesters A and B. Each granted op is latched, held on the ALU for
// ALU_LAT cycles, and its result is returned on one tagged response channel
// with backpressure. Illegal opcodes (110/111) bypass the ALU and answer with
// rsp_err=1, rsp_z=0.
// Optional: define ALU_REQ_ARBITER_PERF_EN to add saturating grant/error
// counters (perf_gnt_a, perf_gnt_b, perf_err).
module alu_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    input  logic [2:0]       a_op,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,
    input  logic [2:0]       b_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_s2,
    output logic             alu_s1,
    output logic             alu_s0,
    input  logic [WIDTH-1:0] alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_err
`ifdef ALU_REQ_ARBITER_PERF_EN
    ,
    output logic [15:0]      perf_gnt_a,
    output logic [15:0]      perf_gnt_b,
    output logic [7:0]       perf_err
`endif
);

    localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic             last_q;      // last granted requester: 0 = A, 1 = B
    logic             id_q;        // requester owning the in-flight op
    logic [CW-1:0]    cnt_q;       // cycles spent in EXEC
    logic [WIDTH-1:0] alu_x_q;
    logic [WIDTH-1:0] alu_y_q;
    logic [2:0]       alu_s_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_z_q;

    logic             gnt_a, gnt_b;
    logic             hs_a, hs_b, hs_any;
    logic [WIDTH-1:0] sel_x, sel_y;
    logic [2:0]       sel_op;
    logic             sel_ill;

    // Round robin: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_a = a_valid & (~b_valid | last_q);
        gnt_b = b_valid & (~a_valid | ~last_q);
    end

    // Ready only while idle; forced low during reset so every output reads 0.
    assign a_ready = gnt_a & (state_q == IDLE) & ~rst;
    assign b_ready = gnt_b & (state_q == IDLE) & ~rst;
    assign hs_a    = a_valid & a_ready;
    assign hs_b    = b_valid & b_ready;
    assign hs_any  = hs_a | hs_b;

    // Mux the accepted request; only meaningful on a handshake cycle.
    always_comb begin
        sel_x   = hs_b ? b_x  : a_x;
        sel_y   = hs_b ? b_y  : a_y;
        sel_op  = hs_b ? b_op : a_op;
        sel_ill = sel_op[2] & sel_op[1];
    end

    // Sequencer: accept, drive the ALU for ALU_LAT cycles, hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_s_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_z_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_any) begin
                        last_q <= hs_b;
                        id_q   <= hs_b;
                        if (sel_ill) begin
                            // ALU is skipped entirely for illegal opcodes.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= hs_b;
                            rsp_err_q   <= 1'b1;
                            rsp_z_q     <= '0;
                        end else begin
                            state_q <= EXEC;
                            cnt_q   <= '0;
                            alu_x_q <= sel_x;
                            alu_y_q <= sel_y;
                            alu_s_q <= sel_op;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= 1'b0;
                        rsp_z_q     <= alu_z;
                        alu_x_q     <= '0;
                        alu_y_q     <= '0;
                        alu_s_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_id_q    <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_z_q     <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_s2    = alu_s_q[2];
    assign alu_s1    = alu_s_q[1];
    assign alu_s0    = alu_s_q[0];
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_REQ_ARBITER_PERF_EN
    logic [15:0] perf_gnt_a_q, perf_gnt_a_d;
    logic [15:0] perf_gnt_b_q, perf_gnt_b_d;
    logic [7:0]  perf_err_q,   perf_err_d;

    // Saturating event counters for grants and illegal-op accepts.
    always_comb begin
        perf_gnt_a_d = perf_gnt_a_q;
        perf_gnt_b_d = perf_gnt_b_q;
        perf_err_d   = perf_err_q;
        if (hs_a && (perf_gnt_a_q != '1))           perf_gnt_a_d = perf_gnt_a_q + 1'b1;
        if (hs_b && (perf_gnt_b_q != '1))           perf_gnt_b_d = perf_gnt_b_q + 1'b1;
        if (hs_any && sel_ill && (perf_err_q != '1)) perf_err_d  = perf_err_q + 1'b1;
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_gnt_a_q <= '0;
            perf_gnt_b_q <= '0;
            perf_err_q   <= '0;
        end else begin
            perf_gnt_a_q <= perf_gnt_a_d;
            perf_gnt_b_q <= perf_gnt_b_d;
            perf_err_q   <= perf_err_d;
        end
    end

    assign perf_gnt_a = perf_gnt_a_q;
    assign perf_gnt_b = perf_gnt_b_q;
    assign perf_err   = perf_err_q;
`endif

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 8-bit ALU (ops AND/OR/NOT/XOR/ADD/SUB on 3-bit select s2,s1,s0) between two requesters, A and B.
- Round-robin arbitration with a valid/ready handshake per requester.
- Sequences each granted operation onto the ALU, waits the configured ALU latency, captures the result and returns it on a single tagged response channel with backpressure.
- Sits between the two client blocks and the ALU instance.

Parameters:
- WIDTH, 8, operand/result width; must match ALU width.
- ALU_LAT, 1, cycles the operands are held on the ALU before z is captured; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has an operation.
- a_ready  output  1  A's operation accepted this cycle.
- a_x, a_y  input  WIDTH each  A operands.
- a_op  input  3  A opcode {s2,s1,s0}.
- b_valid, b_ready, b_x, b_y, b_op  same as A, for requester B.
- alu_x, alu_y  output  WIDTH  ALU operands.
- alu_s2, alu_s1, alu_s0  output  1 each  ALU select.
- alu_z  input  WIDTH  ALU result.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  0 = A, 1 = B.
- rsp_z  output  WIDTH  captured result.
- rsp_err  output  1  illegal opcode (110/111).

Behaviour:
- Reset values (async, immediate on rst=1):
  - state IDLE; all outputs 0; lat counter 0.
  - Round-robin pointer last_grant = B, so A wins the first tie.
- Reset mid-operation: operation and any pending response are discarded; no response is produced for it.
- Opcodes: 000 AND, 001 OR, 010 NOT x, 011 XOR, 100 ADD mod 2^WIDTH (carry dropped), 101 SUB x-y mod 2^WIDTH. 110/111 are illegal.
- IDLE:
  - a_ready/b_ready are combinational and asserted only in IDLE, for the granted requester only.
  - Only A valid: grant A. Only B valid: grant B. Both valid: grant the one not equal to last_grant.
  - On handshake (valid & ready): latch x, y, op and id into internal registers; update last_grant.
  - Legal op -> EXEC. Illegal op -> RESP with rsp_err=1, rsp_z=0; the ALU is never driven.
- EXEC:
  - alu_x/alu_y/alu_s* are driven from the latched registers for exactly ALU_LAT cycles.
  - On the cycle the counter equals ALU_LAT-1: register alu_z into rsp_z, set rsp_err=0, go to RESP.
  - In all other states alu_x, alu_y and alu_s* are 0.
- RESP:
  - rsp_valid=1; rsp_id, rsp_z and rsp_err are stable until rsp_ready=1.
  - On the handshake cycle -> IDLE; rsp_valid deasserts the next cycle.
  - No new request is accepted in RESP, including in the handshake cycle.
- Latency, a_valid accept to rsp_valid: ALU_LAT+1 cycles (legal op), 1 cycle (illegal op).
- Minimum issue interval: ALU_LAT+2 cycles with rsp_ready held high.
- Requester valid dropped before grant: no effect; arbitration is re-evaluated every IDLE cycle.
- Requester inputs changing after the handshake: no effect on the in-flight operation (latched values are used).
- Starvation: with both requesters valid continuously, grants strictly alternate.

Optional Feature:
- Macro ALU_REQ_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_gnt_a and perf_gnt_b (16 bits each) and perf_err (8 bits).
  - Each counter increments on the corresponding grant or illegal-op handshake and saturates at all-ones.
  - All counters clear on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then A: x=0xAA, y=0xCC, op=000, ALU_LAT=1 -> a_ready in accept cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_z=0x88, rsp_err=0.
- A issues ops 001, 010, 011, 100, 101 on 0xAA/0xCC, rsp_ready=1 -> rsp_z = 0xEE, 0x55, 0x66, 0x76 (carry dropped), 0xDE in order; ALU ports are 0 outside EXEC.
- A and B both valid continuously for 4 ops each (A x=0x01, B x=0x02, op=100, y=0x01) -> grants A,B,A,B,...; rsp_z alternates 0x02/0x03 with matching rsp_id.
- B op=111 -> rsp_valid one cycle after accept, rsp_err=1, rsp_z=0; alu_s* stay 0 throughout.
- rsp_ready held 0 for 5 cycles while A and B are valid -> rsp_valid/rsp_z stable, a_ready=b_ready=0; the next grant occurs only after the response handshake.
- rst pulsed during EXEC with ALU_LAT=3 -> all outputs 0 immediately, no response emitted; first grant after reset goes to A on a tie.
